// File: rtl/sprite_line_scheduler_if.sv
// Object attribute RAM read port between the sprite line scheduler (master)
// and the active object RAM (slave).
interface sprite_line_scheduler_if #(
  parameter int IDX_W = 3
);
  logic             obj_rd_en;
  logic [IDX_W-1:0] obj_rd_idx;
  logic [7:0]       obj_rd_y;
  logic [7:0]       obj_rd_size;

  modport master (output obj_rd_en, obj_rd_idx, input obj_rd_y, obj_rd_size);
  modport slave  (input obj_rd_en, obj_rd_idx, output obj_rd_y, obj_rd_size);
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans the attribute table at hblank and commits up to SLOTS hits.
// Optional macro SPRITE_LINE_SCHED_EARLY_EXIT_EN stops reading on the first overflowing hit.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int IDX_W       = 3,
  parameter int SLOTS       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   line_start,
  input  logic [7:0]             next_line,
  sprite_line_scheduler_if.master obj,
  output logic [SLOTS-1:0]       slot_valid,
  output logic [SLOTS*IDX_W-1:0] slot_idx,
  output logic [SLOTS*4-1:0]     slot_row,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   line_miss
);

  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

  // Returns {hit, row}; the 9-bit difference keeps lines above the sprite from wrapping.
  function automatic logic [4:0] cmp_hit(input logic [7:0] line, input logic [7:0] y,
                                         input logic [3:0] h_m1);
    logic [8:0] diff;
    diff    = {1'b0, line} - {1'b0, y};
    cmp_hit = {(y != 8'hFF) && !diff[8] && (diff <= {5'b0, h_m1}), diff[3:0]};
  endfunction

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic [7:0]               line_q, line_d;
  logic [CNT_W-1:0]         hits_q, hits_d;
  logic                     wovf_q, wovf_d;
  logic [IDX_W-1:0]         wl_idx_q [SLOTS];
  logic [IDX_W-1:0]         wl_idx_d [SLOTS];
  logic [3:0]               wl_row_q [SLOTS];
  logic [3:0]               wl_row_d [SLOTS];
  logic                     vld_p1_q, vld_p1_d;
  logic [IDX_W-1:0]         idx_p1_q, idx_p1_d;
  logic [SLOTS-1:0]         slot_valid_q, slot_valid_d;
  logic [SLOTS*IDX_W-1:0]   slot_idx_q, slot_idx_d;
  logic [SLOTS*4-1:0]       slot_row_q, slot_row_d;
  logic                     ovf_q, ovf_d;
  logic                     miss_q, miss_d;
  logic [4:0]               cmp_res;
  logic                     cmp_fire;
  logic                     unused_size_hi;

  assign unused_size_hi = &{1'b0, obj.obj_rd_size[7:4]};

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    line_d       = line_q;
    hits_d       = hits_q;
    wovf_d       = wovf_q;
    wl_idx_d     = wl_idx_q;
    wl_row_d     = wl_row_q;
    vld_p1_d     = 1'b0;
    idx_p1_d     = idx_p1_q;
    slot_valid_d = slot_valid_q;
    slot_idx_d   = slot_idx_q;
    slot_row_d   = slot_row_q;
    ovf_d        = ovf_q;
    miss_d       = miss_q;
    obj.obj_rd_en  = 1'b0;
    obj.obj_rd_idx = rd_cnt_q;

    // p1: compare the attribute returned for the index read last cycle
    cmp_res  = cmp_hit(line_q, obj.obj_rd_y, obj.obj_rd_size[3:0]);
    cmp_fire = vld_p1_q && cmp_res[4];
    if (cmp_fire) begin
      if (hits_q < CNT_W'(SLOTS)) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (CNT_W'(k) == hits_q) begin
            wl_idx_d[k] = idx_p1_q;
            wl_row_d[k] = cmp_res[3:0];
          end
        end
        hits_d = hits_q + 1'b1;
      end else begin
        wovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (line_start && enable) begin
          state_d  = SCAN;
          line_d   = next_line;
          hits_d   = '0;
          wovf_d   = 1'b0;
          rd_cnt_d = '0;
          miss_d   = 1'b0;
          for (int k = 0; k < SLOTS; k++) begin
            wl_idx_d[k] = '0;
            wl_row_d[k] = '0;
          end
        end
      end
      SCAN: begin
        obj.obj_rd_en = 1'b1;
        vld_p1_d      = 1'b1;
        idx_p1_d      = rd_cnt_q;
        rd_cnt_d      = rd_cnt_q + 1'b1;
`ifdef SPRITE_LINE_SCHED_EARLY_EXIT_EN
        if (rd_cnt_q == LAST_IDX || (cmp_fire && hits_q == CNT_W'(SLOTS))) state_d = DRAIN;
`else
        if (rd_cnt_q == LAST_IDX) state_d = DRAIN;
`endif
      end
      DRAIN: begin
        state_d = COMMIT;
        ovf_d   = wovf_d;
        for (int k = 0; k < SLOTS; k++) begin
          slot_valid_d[k]              = (CNT_W'(k) < hits_d);
          slot_idx_d[k*IDX_W +: IDX_W] = wl_idx_d[k];
          slot_row_d[k*4 +: 4]         = wl_row_d[k];
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (line_start && enable && state_q != IDLE) miss_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      hits_q       <= '0;
      wovf_q       <= 1'b0;
      vld_p1_q     <= 1'b0;
      slot_valid_q <= '0;
      slot_idx_q   <= '0;
      slot_row_q   <= '0;
      ovf_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      hits_q       <= hits_d;
      wovf_q       <= wovf_d;
      vld_p1_q     <= vld_p1_d;
      slot_valid_q <= slot_valid_d;
      slot_idx_q   <= slot_idx_d;
      slot_row_q   <= slot_row_d;
      ovf_q        <= ovf_d;
      miss_q       <= miss_d;
    end
  end

  // Working-list data is cleared on every accepted line, so it needs no reset.
  always_ff @(posedge clk) begin
    line_q   <= line_d;
    idx_p1_q <= idx_p1_d;
    wl_idx_q <= wl_idx_d;
    wl_row_q <= wl_row_d;
  end

  assign slot_valid = slot_valid_q;
  assign slot_idx   = slot_idx_q;
  assign slot_row   = slot_row_q;
  assign overflow   = ovf_q;
  assign line_miss  = miss_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == COMMIT);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: a list-based reference model predicts each commit.
module tb_sprite_line_scheduler;

  localparam int NS = 8;
  localparam int IW = 3;
  localparam int SL = 4;

  typedef struct {
    logic [SL-1:0]    v;
    logic [SL*IW-1:0] idx;
    logic [SL*4-1:0]  row;
    logic             ovf;
    int               t_issue;
    int               nreads;
    int               done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic line_start = 1'b0;
  logic [7:0] next_line = '0;
  logic [SL-1:0]    slot_valid;
  logic [SL*IW-1:0] slot_idx;
  logic [SL*4-1:0]  slot_row;
  logic busy, done, overflow, line_miss;

  sprite_line_scheduler_if #(.IDX_W(IW)) obj_bus ();

  sprite_line_scheduler #(.NUM_SPRITES(NS), .IDX_W(IW), .SLOTS(SL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .line_start(line_start), .next_line(next_line),
    .obj(obj_bus), .slot_valid(slot_valid), .slot_idx(slot_idx), .slot_row(slot_row),
    .busy(busy), .done(done), .overflow(overflow), .line_miss(line_miss)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem_y [NS];
  logic [7:0] mem_sz [NS];

  // Synchronous one-port attribute RAM
  always @(posedge clk) begin
    if (obj_bus.obj_rd_en) begin
      obj_bus.obj_rd_y    <= mem_y[obj_bus.obj_rd_idx];
      obj_bus.obj_rd_size <= mem_sz[obj_bus.obj_rd_idx];
    end
  end

  exp_t sb[$];
  logic exp_miss = 1'b0;
  int checks = 0;
  int errors = 0;

  function automatic exp_t model(input int nl, input int t);
    exp_t e;
    int h, first_ovf, y, ht;
    e = '{default: 0};
    h = 0;
    first_ovf = -1;
    for (int i = 0; i < NS; i++) begin
      y  = int'(mem_y[i]);
      ht = int'(mem_sz[i]) % 16;
      if (y != 255 && nl >= y && nl - y <= ht) begin
        if (h < SL) begin
          e.v[h] = 1'b1;
          e.idx[h*IW +: IW] = IW'(i);
          e.row[h*4 +: 4]   = 4'(nl - y);
          h++;
        end else begin
          if (!e.ovf) first_ovf = i;
          e.ovf = 1'b1;
        end
      end
    end
    e.t_issue  = t;
    e.nreads   = NS;
    e.done_cyc = t + NS + 2;
`ifdef SPRITE_LINE_SCHED_EARLY_EXIT_EN
    if (first_ovf >= 0 && first_ovf + 2 < NS) begin
      e.nreads   = first_ovf + 2;
      e.done_cyc = t + first_ovf + 4;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: checks read port, busy/done timing, sticky miss, and held slot list every cycle.
  exp_t hold = '{default: 0};
  exp_t me;
  logic rst_d = 1'b0;
  logic have, exp_en;
  always @(negedge clk) begin
    if (rst) begin
      if (rst_d)
        chk("reset_outputs", 32'({slot_valid, slot_idx, slot_row, overflow, done, busy,
                                  line_miss, obj_bus.obj_rd_en}), 32'd0);
      sb.delete();
      hold  = '{default: 0};
      rst_d = 1'b1;
    end else begin
      rst_d = 1'b0;
      have  = (sb.size() > 0);
      me    = have ? sb[0] : '{default: 0};
      exp_en = have && cyc > me.t_issue && cyc <= me.t_issue + me.nreads;
      chk("rd_en", 32'(obj_bus.obj_rd_en), 32'(exp_en));
      if (exp_en) chk("rd_idx", 32'(obj_bus.obj_rd_idx), 32'(cyc - me.t_issue - 1));
      chk("busy", 32'(busy), 32'(have && cyc > me.t_issue && cyc <= me.done_cyc));
      chk("line_miss", 32'(line_miss), 32'(exp_miss));
      chk("done", 32'(done), 32'(have && cyc == me.done_cyc));
      if (have && cyc >= me.done_cyc) begin
        void'(sb.pop_front());
        hold = me;
      end
      chk("slot_valid", 32'(slot_valid), 32'(hold.v));
      chk("slot_idx", 32'(slot_idx), 32'(hold.idx));
      chk("slot_row", 32'(slot_row), 32'(hold.row));
      chk("overflow", 32'(overflow), 32'(hold.ovf));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_line(input logic [7:0] nl);
    line_start = 1'b1;
    next_line  = nl;
    sb.push_back(model(int'(nl), cyc));
    wait_cyc(1);
    line_start = 1'b0;
    exp_miss   = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin
      mem_y[i]  = 8'hFF;
      mem_sz[i] = 8'h00;
    end
  endtask

  initial begin
    clear_table();
    @(posedge clk); #1;
    rst = 1'b1; line_start = 1'b1; next_line = 8'd12;
    wait_cyc(4);
    rst = 1'b0; line_start = 1'b0;
    wait_cyc(2);

    // Single hit
    mem_y[3] = 8'd10; mem_sz[3] = 8'h03;
    issue_line(8'd12); wait_cyc(11);

    // Row boundaries for a height-4 sprite at y=10
    clear_table();
    mem_y[0] = 8'd10; mem_sz[0] = 8'h03;
    issue_line(8'd13); wait_cyc(11);
    issue_line(8'd14); wait_cyc(11);
    issue_line(8'd9);  wait_cyc(11);
    mem_y[0] = 8'd250; mem_sz[0] = 8'h0F;
    issue_line(8'd2);  wait_cyc(11);

    // Overflow
    clear_table();
    for (int i = 0; i < 6; i++) begin mem_y[i] = 8'd0; mem_sz[i] = 8'h0F; end
    issue_line(8'd5); wait_cyc(11);

    // Collision at T+4, then an accepted line clears the miss
    issue_line(8'd5); wait_cyc(3);
    line_start = 1'b1; next_line = 8'd20;
    wait_cyc(1);
    line_start = 1'b0; exp_miss = 1'b1;
    wait_cyc(7);
    issue_line(8'd7); wait_cyc(11);

    // Enable dropped mid-scan still commits
    issue_line(8'd3); wait_cyc(2);
    enable = 1'b0; wait_cyc(9);
    line_start = 1'b1; wait_cyc(1); line_start = 1'b0;
    enable = 1'b1; wait_cyc(1);

    // Reset mid-scan at T+5
    issue_line(8'd5); wait_cyc(4);
    rst = 1'b1; exp_miss = 1'b0;
    wait_cyc(1);
    rst = 1'b0; wait_cyc(3);
    issue_line(8'd5); wait_cyc(11);

    // Randomized tables and lines
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(0, 5))
          0:       mem_y[i] = 8'hFF;
          1:       mem_y[i] = 8'($urandom_range(240, 254));
          default: mem_y[i] = 8'($urandom_range(0, 40));
        endcase
        mem_sz[i] = 8'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0; line_start = 1'b1; next_line = 8'($urandom);
        wait_cyc(1);
        line_start = 1'b0; enable = 1'b1;
        wait_cyc(2);
      end
      issue_line(8'($urandom_range(0, 60)));
      wait_cyc(10 + $urandom_range(0, 3));
    end

    wait_cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluator for the sprite overlay engine.
- On each horizontal-blank start it walks the sprite attribute table and selects up to SLOTS sprites whose vertical extent covers the upcoming logical line.
- It publishes a stable slot list, with sprite index and row-within-sprite for each slot, to the pixel renderer for the whole next line.
- It sits between the active object RAM (one synchronous read port) and the renderer, and replaces brute-force all-sprite compare in the pixel path.

Parameters:
- NUM_SPRITES, 8, number of attribute entries scanned per line (power of 2, 2..16).
- IDX_W, 3, sprite index width, equal to log2(NUM_SPRITES).
- SLOTS, 4, maximum sprites selected per line (1..8).

Ports:
- clk, input, 1, project clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, scheduler enable; when low, line_start is ignored.
- line_start, input, 1, one-cycle pulse at hblank start.
- next_line, input, 8, logical y (pix_y>>2) of the line to evaluate; sampled with line_start.
- obj_rd_en, output, 1, attribute read strobe.
- obj_rd_idx, output, IDX_W, sprite index being read.
- obj_rd_y, input, 8, sprite y; valid the cycle after obj_rd_en.
- obj_rd_size, input, 8, sprite size byte; [3:0] = height-1. Valid the cycle after obj_rd_en.
- slot_valid, output, SLOTS, per-slot valid.
- slot_idx, output, SLOTS*IDX_W, sprite index per slot; slot k occupies bits [k*IDX_W +: IDX_W].
- slot_row, output, SLOTS*4, row within sprite per slot (next_line - y).
- busy, output, 1, scan in progress.
- done, output, 1, one-cycle pulse when a new slot list is committed.
- overflow, output, 1, more than SLOTS hits found on the last committed line.
- line_miss, output, 1, sticky: a line_start arrived while busy.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Reset asserted mid-scan: the scan is abandoned, no done pulse, all outputs cleared.
- FSM states: IDLE, SCAN, DRAIN, COMMIT.
- IDLE:
  - On line_start && enable: latch next_line, clear the working list and the hit counter, set rd counter to 0, go to SCAN.
  - busy goes high the next cycle.
- SCAN:
  - obj_rd_en = 1 with obj_rd_idx = rd counter; the counter increments every cycle.
  - Leave for DRAIN after issuing index NUM_SPRITES-1.
  - Exactly NUM_SPRITES back-to-back reads; the counter does not wrap.
- Compare (SCAN and DRAIN), one cycle after each read, for the index issued the previous cycle:
  - Hit when y != 8'hFF && next_line >= y && (next_line - y) <= size[3:0].
  - Use 9-bit arithmetic; no wrap-around. A sprite at y = 250, height 16 does not hit line 2.
  - y = 8'hFF marks a disabled entry and never hits.
  - A hit with hit count < SLOTS writes slot[hit count] = {idx, row} and increments the count.
  - A hit with hit count == SLOTS sets working overflow; no slot is modified.
  - Slots fill in ascending sprite index order, so lower index means higher priority.
- DRAIN: one cycle to compare the final read, then go to COMMIT.
- COMMIT:
  - Copy the working list to the slot_* outputs; slot_valid = (1<<hits)-1. Unused slots have valid=0 and idx/row=0.
  - Copy overflow. Pulse done for one cycle, clear busy, go to IDLE.
- Latency: line_start in cycle T gives reads in T+1..T+NUM_SPRITES, COMMIT/done in T+NUM_SPRITES+2 with outputs visible from the same edge.
  - NUM_SPRITES=8 gives done at T+10.
- Stability: slot_* outputs change only in COMMIT and hold between commits.
- line_start while busy: ignored, sets line_miss. line_miss is cleared on the next accepted line_start.
- line_start in the COMMIT cycle counts as busy.
- enable deasserted mid-scan: the scan completes and commits normally.

Optional Feature:
- Macro: SPRITE_LINE_SCHED_EARLY_EXIT_EN.
- When defined: on the first overflowing hit, SCAN stops issuing reads and goes to DRAIN. Any read already in flight is still compared but cannot change slots. COMMIT follows, so done can arrive earlier than T+NUM_SPRITES+2.
- When undefined: all NUM_SPRITES entries are always read, and done timing is fixed.

Test Plan:
- Reset with line_start held high: all outputs 0, no obj_rd_en.
- Single hit: sprite 3 with y=10 and size=0x03; all others y=0xFF; line_start with next_line=12. Expect reads idx 0..7 in T+1..T+8, done at T+10, slot_valid=0001, slot0 idx=3 row=2, overflow=0.
- Boundaries: sprite 0 y=10 height 4 (size[3:0]=3).
  - next_line=13: hit, row 3.
  - next_line=14: no hit.
  - next_line=9: no hit.
  - sprite y=250 height 16, next_line=2: no hit.
- Overflow: sprites 0..5 all y=0 height 16, next_line=5.
  - Expect slot_valid=1111, idx 0,1,2,3, overflow=1, done at T+10.
  - With EARLY_EXIT_EN, done arrives earlier than T+10 and slots/overflow are identical.
- Collision/miss: second line_start at T+4. It is ignored, line_miss=1 and the original commit arrives at T+10. The next line_start in IDLE clears line_miss.
- Reset mid-scan: assert rst at T+5. No done pulse, outputs 0. A fresh line_start afterwards completes normally.
